// File: rtl/wb_arb_pkg.sv
// Shared types and Wishbone cycle-type constants for the 2:1 Wishbone arbiter.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GNT_M0 = 2'b01,
    GNT_M1 = 2'b10
  } arb_state_t;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } master_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;

endpackage

// File: rtl/wb_if.sv
// Wishbone B3 bus bundle (no RTY); the master modport drives the request side.
interface wb_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0]   adr;
  logic [DW-1:0]   dat_w;
  logic [DW-1:0]   dat_r;
  logic            cyc;
  logic            stb;
  logic            we;
  logic [DW/8-1:0] sel;
  logic [2:0]      cti;
  logic [1:0]      bte;
  logic            ack;
  logic            err;

  modport master (output adr, dat_w, cyc, stb, we, sel, cti, bte,
                  input  dat_r, ack, err);
  modport slave  (input  adr, dat_w, cyc, stb, we, sel, cti, bte,
                  output dat_r, ack, err);
endinterface

// File: rtl/wb_arb_timeout.sv
// Slave no-response watchdog: pulses fire_o once a strobe has waited TIMEOUT cycles.
module wb_arb_timeout #(
  parameter int TIMEOUT = 256
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic active_i,
  output logic fire_o
);

  if (TIMEOUT > 0) begin : g_wd
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign fire_o = (cnt_q == CW'(TIMEOUT));

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
      cnt_d = cnt_q;
      if (clr_i || fire_o || !active_i) cnt_d = '0;
      else                              cnt_d = cnt_q + CW'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
    end
  end else begin : g_off
    assign fire_o = 1'b0;
  end

endmodule

// File: rtl/wb_arb_2to1.sv
// Two-master Wishbone B3 arbiter: round-robin on ties, grant held while the owner keeps CYC.
module wb_arb_2to1
  import wb_arb_pkg::*;
#(
  parameter int TIMEOUT           = 256,
  parameter bit M0_PRIO_AFTER_RST = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  wb_if.slave  m0,
  wb_if.slave  m1,
  wb_if.master s,
  output logic timeout_o
);

  localparam master_t LAST_RST = M0_PRIO_AFTER_RST ? M1 : M0;

  arb_state_t state_q, state_d;
  master_t    last_q, last_d;
  logic       own_m0, own_m1;
  logic       stb_raw;
  logic       fire;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      last_q  <= LAST_RST;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (m0.cyc && m1.cyc) state_d = (last_q == M1) ? GNT_M0 : GNT_M1;
        else if (m0.cyc)      state_d = GNT_M0;
        else if (m1.cyc)      state_d = GNT_M1;
      end
      // Handover goes straight to the waiting master, no idle bubble.
      GNT_M0:  if (!m0.cyc) state_d = m1.cyc ? GNT_M1 : IDLE;
      GNT_M1:  if (!m1.cyc) state_d = m0.cyc ? GNT_M0 : IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) begin
      if (state_d == GNT_M0)      last_d = M0;
      else if (state_d == GNT_M1) last_d = M1;
    end
  end

  assign own_m0 = (state_q == GNT_M0);
  assign own_m1 = (state_q == GNT_M1);

  always_comb begin
    s.cyc   = 1'b0;
    stb_raw = 1'b0;
    s.we    = 1'b0;
    s.adr   = '0;
    s.dat_w = '0;
    s.sel   = '0;
    s.cti   = CTI_CLASSIC;
    s.bte   = BTE_LINEAR;
    if (own_m0) begin
      s.cyc   = m0.cyc;
      stb_raw = m0.stb;
      s.we    = m0.we;
      s.adr   = m0.adr;
      s.dat_w = m0.dat_w;
      s.sel   = m0.sel;
      s.cti   = m0.cti;
      s.bte   = m0.bte;
    end else if (own_m1) begin
      s.cyc   = m1.cyc;
      stb_raw = m1.stb;
      s.we    = m1.we;
      s.adr   = m1.adr;
      s.dat_w = m1.dat_w;
      s.sel   = m1.sel;
      s.cti   = m1.cti;
      s.bte   = m1.bte;
    end
  end

  // A firing watchdog withdraws the strobe and answers the owner with ERR itself.
  assign s.stb     = stb_raw & ~fire;
  assign timeout_o = fire;

  assign m0.ack   = own_m0 & s.ack & ~rst_i;
  assign m0.err   = own_m0 & (s.err | fire) & ~rst_i;
  assign m1.ack   = own_m1 & s.ack & ~rst_i;
  assign m1.err   = own_m1 & (s.err | fire) & ~rst_i;
  assign m0.dat_r = s.dat_r;
  assign m1.dat_r = s.dat_r;

  wb_arb_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (state_d != state_q),
    .active_i (stb_raw & ~s.ack & ~s.err),
    .fire_o   (fire)
  );

endmodule

// File: tb/tb_wb_arb_2to1.sv
// Self-checking bench for wb_arb_2to1: directed scenarios plus randomized traffic against an owner-based model.
module tb_wb_arb_2to1;
  import wb_arb_pkg::*;

  localparam int TIMEOUT = 8;

  logic clk = 1'b0;
  logic rst;
  logic timeout;
  int   n_checks = 0;
  int   n_errs   = 0;

  always #5 clk = ~clk;

  wb_if #(.AW(32), .DW(32)) m0_if ();
  wb_if #(.AW(32), .DW(32)) m1_if ();
  wb_if #(.AW(32), .DW(32)) s_if ();

  wb_arb_2to1 #(
    .TIMEOUT           (TIMEOUT),
    .M0_PRIO_AFTER_RST (1'b1)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .m0        (m0_if),
    .m1        (m1_if),
    .s         (s_if),
    .timeout_o (timeout)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the bus, who was granted last, how long the strobe has stalled.
  int          owner = -1;
  int          last  = 1;
  int          stall = 0;
  logic        mc[2], ms[2], mw[2];
  logic [31:0] ma[2], md[2];
  logic [3:0]  msel[2];
  logic [2:0]  mcti[2];
  logic [1:0]  mbte[2];

  always @(negedge clk) begin
    int   nxt;
    logic fired;
    mc[0] = m0_if.cyc; ms[0] = m0_if.stb; mw[0] = m0_if.we; ma[0] = m0_if.adr;
    md[0] = m0_if.dat_w; msel[0] = m0_if.sel; mcti[0] = m0_if.cti; mbte[0] = m0_if.bte;
    mc[1] = m1_if.cyc; ms[1] = m1_if.stb; mw[1] = m1_if.we; ma[1] = m1_if.adr;
    md[1] = m1_if.dat_w; msel[1] = m1_if.sel; mcti[1] = m1_if.cti; mbte[1] = m1_if.bte;

    fired = (owner >= 0) && (stall == TIMEOUT);
    check("m_timeout_o", 32'(timeout), 32'(fired));
    check("m_m0_dat_r", m0_if.dat_r, s_if.dat_r);
    check("m_m1_dat_r", m1_if.dat_r, s_if.dat_r);
    if (owner < 0) begin
      check("m_s_cyc", 32'(s_if.cyc), 0);
      check("m_s_stb", 32'(s_if.stb), 0);
      check("m_s_we", 32'(s_if.we), 0);
      check("m_m0_ack", 32'(m0_if.ack), 0);
      check("m_m0_err", 32'(m0_if.err), 0);
      check("m_m1_ack", 32'(m1_if.ack), 0);
      check("m_m1_err", 32'(m1_if.err), 0);
    end else begin
      check("m_s_cyc", 32'(s_if.cyc), 32'(mc[owner]));
      check("m_s_stb", 32'(s_if.stb), 32'(ms[owner] && !fired));
      check("m_s_we", 32'(s_if.we), 32'(mw[owner]));
      check("m_s_adr", s_if.adr, ma[owner]);
      check("m_s_dat_w", s_if.dat_w, md[owner]);
      check("m_s_sel", 32'(s_if.sel), 32'(msel[owner]));
      check("m_s_cti", 32'(s_if.cti), 32'(mcti[owner]));
      check("m_s_bte", 32'(s_if.bte), 32'(mbte[owner]));
      check("m_m0_ack", 32'(m0_if.ack), 32'(owner == 0 && s_if.ack && !rst));
      check("m_m0_err", 32'(m0_if.err), 32'(owner == 0 && (s_if.err || fired) && !rst));
      check("m_m1_ack", 32'(m1_if.ack), 32'(owner == 1 && s_if.ack && !rst));
      check("m_m1_err", 32'(m1_if.err), 32'(owner == 1 && (s_if.err || fired) && !rst));
    end

    if (rst) begin
      owner = -1;
      last  = 1;
      stall = 0;
    end else begin
      nxt = owner;
      if (owner < 0) begin
        if (mc[0] && mc[1]) nxt = 1 - last;
        else if (mc[0])     nxt = 0;
        else if (mc[1])     nxt = 1;
      end else if (!mc[owner]) begin
        nxt = mc[1 - owner] ? 1 - owner : -1;
      end
      if (nxt >= 0 && nxt != owner) last = nxt;
      if (nxt != owner || owner < 0 || fired || !ms[owner] || s_if.ack || s_if.err) stall = 0;
      else stall++;
      owner = nxt;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic set_m(input int k, input logic cyc, input logic stb, input logic we,
                       input logic [31:0] adr, input logic [2:0] cti);
    if (k == 0) begin
      m0_if.cyc = cyc; m0_if.stb = stb; m0_if.we = we; m0_if.adr = adr;
      m0_if.dat_w = adr ^ 32'hA5A5_0000; m0_if.sel = 4'($urandom()); m0_if.cti = cti;
      m0_if.bte = 2'($urandom());
    end else begin
      m1_if.cyc = cyc; m1_if.stb = stb; m1_if.we = we; m1_if.adr = adr;
      m1_if.dat_w = adr ^ 32'h5A5A_0000; m1_if.sel = 4'($urandom()); m1_if.cti = cti;
      m1_if.bte = 2'($urandom());
    end
  endtask

  task automatic clear_inputs();
    set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, CTI_CLASSIC);
    set_m(1, 1'b0, 1'b0, 1'b0, 32'h0, CTI_CLASSIC);
    s_if.ack   = 1'b0;
    s_if.err   = 1'b0;
    s_if.dat_r = 32'h0;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    sample();
    check("rst_s_cyc", 32'(s_if.cyc), 0);
    check("rst_s_stb", 32'(s_if.stb), 0);
    check("rst_s_we", 32'(s_if.we), 0);
    check("rst_m0_ack", 32'(m0_if.ack), 0);
    check("rst_m1_err", 32'(m1_if.err), 0);
    check("rst_timeout", 32'(timeout), 0);

    // Single read by m0 with a two-cycle slave latency.
    step(); set_m(0, 1'b1, 1'b1, 1'b0, 32'h0000_0100, CTI_CLASSIC);
    sample(); check("t1_cyc_latency", 32'(s_if.cyc), 0);
    step(); sample();
    check("t1_s_cyc", 32'(s_if.cyc), 1);
    check("t1_s_adr", s_if.adr, 32'h0000_0100);
    step(); sample(); check("t1_no_ack_yet", 32'(m0_if.ack), 0);
    step(); s_if.ack = 1'b1; s_if.dat_r = 32'hDEAD_BEEF;
    sample();
    check("t1_m0_ack", 32'(m0_if.ack), 1);
    check("t1_m0_dat_r", m0_if.dat_r, 32'hDEAD_BEEF);
    check("t1_m1_ack", 32'(m1_if.ack), 0);
    step(); clear_inputs(); sample(); check("t1_ack_one_cycle", 32'(m0_if.ack), 0);
    step();

    // Simultaneous requests after reset: m0 first, then m1 with no idle bubble.
    rst = 1'b1; step(); rst = 1'b0;
    step(); set_m(0, 1'b1, 1'b1, 1'b0, 32'h10, CTI_CLASSIC); set_m(1, 1'b1, 1'b1, 1'b0, 32'h20, CTI_CLASSIC);
    sample(); check("t2_idle", 32'(s_if.cyc), 0);
    step(); s_if.ack = 1'b1; sample();
    check("t2_first_m0", s_if.adr, 32'h10);
    check("t2_m0_ack", 32'(m0_if.ack), 1);
    check("t2_m1_ack", 32'(m1_if.ack), 0);
    step(); set_m(0, 1'b0, 1'b0, 1'b0, 32'h10, CTI_CLASSIC); s_if.ack = 1'b0; sample();
    step(); s_if.ack = 1'b1; sample();
    check("t2_no_bubble", 32'(s_if.cyc), 1);
    check("t2_then_m1", s_if.adr, 32'h20);
    check("t2_m1_ack", 32'(m1_if.ack), 1);
    step(); set_m(1, 1'b0, 1'b0, 1'b0, 32'h20, CTI_CLASSIC); s_if.ack = 1'b0; sample();
    step(); set_m(0, 1'b1, 1'b1, 1'b0, 32'h10, CTI_CLASSIC); set_m(1, 1'b1, 1'b1, 1'b0, 32'h20, CTI_CLASSIC);
    sample();
    step(); sample(); check("t2_second_tie_m0", s_if.adr, 32'h10);
    step(); clear_inputs(); sample(); step();

    // m1 INCR burst is not interrupted by m0 raising CYC mid-burst.
    step(); set_m(1, 1'b1, 1'b1, 1'b0, 32'h20, CTI_INCR); sample();
    for (int i = 0; i < 4; i++) begin
      step();
      set_m(1, 1'b1, 1'b1, 1'b0, 32'h20 + 32'(4 * i), (i == 3) ? CTI_EOB : CTI_INCR);
      s_if.ack = 1'b1;
      if (i == 1) set_m(0, 1'b1, 1'b1, 1'b1, 32'h300, CTI_CLASSIC);
      sample();
      check("t3_burst_adr", s_if.adr, 32'h20 + 32'(4 * i));
      check("t3_burst_cti", 32'(s_if.cti), (i == 3) ? 32'h7 : 32'h2);
      check("t3_m1_ack", 32'(m1_if.ack), 1);
      check("t3_m0_ack", 32'(m0_if.ack), 0);
    end
    step(); set_m(1, 1'b0, 1'b0, 1'b0, 32'h0, CTI_CLASSIC); s_if.ack = 1'b0; sample();
    check("t3_release", 32'(s_if.cyc), 0);
    step(); sample();
    check("t3_m0_cyc", 32'(s_if.cyc), 1);
    check("t3_m0_adr", s_if.adr, 32'h300);
    step(); clear_inputs(); sample(); step();

    // Watchdog on an unanswered m0 write.
    step(); set_m(0, 1'b1, 1'b1, 1'b1, 32'h400, CTI_CLASSIC); sample();
    for (int i = 1; i <= TIMEOUT; i++) begin
      step(); sample();
      check("t4_stb_wait", 32'(s_if.stb), 1);
      check("t4_no_timeout", 32'(timeout), 0);
    end
    step(); sample();
    check("t4_stb_forced", 32'(s_if.stb), 0);
    check("t4_m0_err", 32'(m0_if.err), 1);
    check("t4_timeout", 32'(timeout), 1);
    step(); set_m(0, 1'b1, 1'b0, 1'b1, 32'h400, CTI_CLASSIC); s_if.ack = 1'b1; sample();
    check("t4_err_one_cycle", 32'(m0_if.err), 0);
    check("t4_timeout_one_cycle", 32'(timeout), 0);
    check("t4_late_ack", 32'(m0_if.ack), 1);
    step(); clear_inputs(); sample(); step();

    // Reset during beat 2 of an m0 burst.
    step(); set_m(0, 1'b1, 1'b1, 1'b0, 32'h500, CTI_INCR); sample();
    step(); s_if.ack = 1'b1; sample(); check("t5_beat1_ack", 32'(m0_if.ack), 1);
    step(); set_m(0, 1'b1, 1'b1, 1'b0, 32'h504, CTI_INCR); set_m(1, 1'b1, 1'b1, 1'b0, 32'h600, CTI_CLASSIC);
    rst = 1'b1; sample();
    check("t5_ack_masked", 32'(m0_if.ack), 0);
    step(); rst = 1'b0; sample();
    check("t5_s_cyc_low", 32'(s_if.cyc), 0);
    check("t5_ack_idle", 32'(m0_if.ack), 0);
    step(); s_if.ack = 1'b0; sample();
    check("t5_tie_m0", s_if.adr, 32'h504);
    step(); clear_inputs(); sample(); step();

    // Slave ERR on an m1 read.
    step(); set_m(1, 1'b1, 1'b1, 1'b0, 32'h4000_0000, CTI_CLASSIC); sample();
    step(); s_if.err = 1'b1; sample();
    check("t6_m1_err", 32'(m1_if.err), 1);
    check("t6_m0_err", 32'(m0_if.err), 0);
    check("t6_timeout", 32'(timeout), 0);
    step(); clear_inputs(); sample(); step();

    // Randomized traffic: a fast slave, then a slow one to exercise the watchdog.
    for (int c = 0; c < 3000; c++) begin
      logic cy, sb;
      step();
      rst = ($urandom_range(0, 299) == 0);
      for (int k = 0; k < 2; k++) begin
        cy = (k == 0) ? m0_if.cyc : m1_if.cyc;
        sb = (k == 0) ? m0_if.stb : m1_if.stb;
        if (cy) cy = ($urandom_range(0, 9) != 0);
        else    cy = ($urandom_range(0, 3) == 0);
        if (!cy)     sb = 1'b0;
        else if (sb) sb = ($urandom_range(0, 7) != 0);
        else         sb = 1'($urandom_range(0, 1));
        set_m(k, cy, sb, 1'($urandom_range(0, 1)), $urandom(), 3'($urandom_range(0, 7)));
      end
      s_if.ack   = ($urandom_range(0, 99) < ((c < 1500) ? 30 : 4));
      s_if.err   = ($urandom_range(0, 99) < 3);
      s_if.dat_r = $urandom();
    end
    step(); rst = 1'b0; clear_inputs();
    sample();
    step();
    sample();
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_arb_2to1.md
Name: wb_arb_2to1

Overview:
- Two-master to one-slave Wishbone B3 arbiter, directly downstream of the CPU wrapper.
- Merges the instruction bus (iwb) and data bus (dwb) onto a single shared memory/peripheral bus.
- Burst-aware: a grant is held while the owning master keeps CYC asserted.
- Round-robin fairness between the two masters.
- Optional watchdog that terminates hung slave cycles with an ERR to the master.

Parameters:
- TIMEOUT, 256: slave no-response limit in clk_i cycles; 0 disables the watchdog.
- M0_PRIO_AFTER_RST, 1: 1 means m0 wins the first tie after reset.

Ports:
- clk_i  in  1  clock; all logic is on the rising edge.
- rst_i  in  1  synchronous reset, active-high.
- m0  wb_if.slave  aw/dw from wb_if  master 0 (iwb).
- m1  wb_if.slave  aw/dw from wb_if  master 1 (dwb).
- s  wb_if.master  aw/dw from wb_if  shared slave bus.
- timeout_o  out  1  one-cycle pulse when the watchdog fires.

Behaviour:
- Interface signals used: ADR, DAT_W, DAT_R, CYC, STB, WE, SEL, CTI, BTE, ACK, ERR. RTY is not supported.
- Reset values:
  - state=IDLE; last_grant = M1 when M0_PRIO_AFTER_RST=1, else M0.
  - s.CYC=0, s.STB=0, s.WE=0.
  - m0/m1 ACK=ERR=0; timeout_o=0; watchdog counter=0.
- States: IDLE, GNT_M0, GNT_M1. The state is registered; output muxing is combinational from the state.
- IDLE:
  - Only m0.CYC=1: next state GNT_M0.
  - Only m1.CYC=1: next state GNT_M1.
  - Both asserted: grant the master that is not last_grant.
  - Arbitration latency is 1 cycle: s.CYC rises the cycle after the master's CYC is first seen in IDLE.
- GNT_Mx:
  - s.{CYC,STB,ADR,DAT_W,WE,SEL,CTI,BTE} = mx.{…}.
  - s.ACK and s.ERR are routed to mx only; the other master sees ACK=ERR=0.
  - s.DAT_R is broadcast to both masters.
- Grant release:
  - While mx.CYC=1 the grant is held regardless of STB or CTI. This covers INCR bursts, CTI=111 end-of-burst and locked RMW.
  - The cycle mx.CYC=0: next state is GNT_My if my.CYC=1, else IDLE. No idle bubble between owners.
  - last_grant is updated on every entry to GNT_Mx.
- While IDLE: s.CYC=s.STB=0. Slave ACK/ERR is ignored and not forwarded.
- Watchdog (TIMEOUT>0):
  - Counter width is $clog2(TIMEOUT+1).
  - Increments each cycle with s.STB=1, s.ACK=0 and s.ERR=0.
  - Clears on ACK, ERR, STB=0, or a grant change.
  - When counter==TIMEOUT, for that one cycle:
    - mx.ERR=1;
    - s.STB is forced to 0;
    - timeout_o=1;
    - counter clears.
  - A late slave ACK in the following cycle is forwarded normally. The master has already seen ERR, and masters are required to drop STB after ERR.
- A slave ACK and ERR in the same cycle are both forwarded; the master resolves it.
- Reset mid-operation (rst_i=1 in any state):
  - Next edge: IDLE, s.CYC=s.STB=0, counter=0, last_grant reinitialised.
  - While rst_i=1, master ACK/ERR are forced to 0.
- Equal-width assumption: m0, m1 and s share aw and dw. There is no width conversion.

Decomposition:
- Package wb_arb_pkg:
  - typedef enum logic[1:0] arb_state_t {IDLE, GNT_M0, GNT_M1};
  - CTI constants: CTI_CLASSIC=3'b000, CTI_CONST=3'b001, CTI_INCR=3'b010, CTI_EOB=3'b111;
  - BTE_LINEAR=2'b00.
- Sub-module wb_arb_timeout:
  - Parameter TIMEOUT.
  - Inputs: clk_i, rst_i, clr_i, active_i (STB & !ACK & !ERR).
  - Output: fire_o.
  - Instantiated once.

Test Plan:
1. m0 single read, ADR=0x0000_0100; slave ACKs 2 cycles after STB with DAT_R=0xDEAD_BEEF -> s.CYC rises 1 cycle after m0.CYC; m0.ACK=1 for one cycle with DAT_R=0xDEAD_BEEF; m1.ACK stays 0.
2. After reset, m0.CYC and m1.CYC both rise in the same cycle -> m0 granted first. m1 is granted the cycle after m0.CYC drops, with no IDLE cycle. A second simultaneous request then goes to m0 (last_grant=M1).
3. m1 4-beat INCR burst (CTI 010,010,010,111; ADR 0x20,0x24,0x28,0x2C); m0 raises CYC during beat 2 -> s.ADR sequence is unchanged and there is no switch mid-burst; m0 is granted the cycle m1.CYC drops.
4. TIMEOUT=8; slave never ACKs m0's write -> after 8 cycles of s.STB=1: m0.ERR=1 and timeout_o=1 for exactly 1 cycle, s.STB=0 in that cycle, counter=0 after.
5. rst_i asserted during beat 2 of an m0 burst -> next cycle s.CYC=0 and state=IDLE; m0.ACK=0 even though the slave ACKs; after release, m0 wins the first tie.
6. Slave returns ERR on an m1 read at ADR 0x4000_0000 -> m1.ERR=1 and m0.ERR=0; timeout_o stays 0.
